// File: rtl/enemy_missile_arbiter_if.sv
// Bundle between the enemy/boss motion blocks, the missile slot blocks and the missile arbiter.
// The master side drives requests and releases; the slave side (the arbiter) returns spawns.
interface enemy_missile_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_W     = 2,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
);
  logic [5:0]            level;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*10-1:0] req_x;
  logic [NUM_REQ*10-1:0] req_y;
  logic [NUM_SLOTS-1:0]  slot_free;
  logic                  spawn_valid;
  logic [SLOT_W-1:0]     spawn_slot;
  logic [REQ_W-1:0]      spawn_src;
  logic [9:0]            spawn_x;
  logic [9:0]            spawn_y;
  logic [NUM_SLOTS-1:0]  slot_busy;

  modport master (
    output level, req, req_x, req_y, slot_free,
    input  spawn_valid, spawn_slot, spawn_src, spawn_x, spawn_y, slot_busy
  );

  modport slave (
    input  level, req, req_x, req_y, slot_free,
    output spawn_valid, spawn_slot, spawn_src, spawn_x, spawn_y, slot_busy
  );
endinterface

// File: rtl/enemy_missile_arbiter.sv
// Round-robin arbiter handing out a fixed pool of enemy-missile slots, one spawn per frame,
// with a per-requester cooldown and gating by the one-hot game level.
module enemy_missile_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         REQ_W     = 2,
  parameter int         NUM_SLOTS = 4,
  parameter int         SLOT_W    = 2,
  parameter int         COOLDOWN  = 30,
  parameter logic [5:0] FIRE_LVL  = 6'b111110
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  enemy_missile_arbiter_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;
  logic   startScreen, fireOk, grantEn, grant;

  logic [NUM_REQ-1:0][7:0] cool_q, cool_d;
  logic [REQ_W-1:0]        ptr_q, ptr_d;
  logic [NUM_SLOTS-1:0]    slot_busy_q, slot_busy_d;
  logic                    spawn_valid_q;
  logic [SLOT_W-1:0]       spawn_slot_q;
  logic [REQ_W-1:0]        spawn_src_q;
  logic [9:0]              spawn_x_q, spawn_y_q;

  logic [NUM_REQ-1:0] eligible;
  logic               winnerFound, slotFound;
  logic [REQ_W-1:0]   winner, cand;
  logic [REQ_W:0]     candSum;
  logic [SLOT_W-1:0]  freeSlot;
  logic [9:0]         winX, winY;

  assign startScreen = (bus.level == 6'b000001);
  assign fireOk      = (|(bus.level & FIRE_LVL)) && !startScreen;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fireOk)  state_d = RUN;
      RUN:     if (!fireOk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The start-screen clear outranks everything, so it also blocks a grant on that edge.
  always_comb begin
    grantEn = (state_q == RUN) && !startScreen;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) eligible[i] = bus.req[i] && (cool_q[i] == 8'd0);
  end

  always_comb begin
    winnerFound = 1'b0;
    winner      = '0;
    candSum     = '0;
    cand        = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      candSum = {1'b0, ptr_q} + (REQ_W+1)'(off);
      if (candSum >= (REQ_W+1)'(NUM_REQ)) candSum = candSum - (REQ_W+1)'(NUM_REQ);
      cand = candSum[REQ_W-1:0];
      if (!winnerFound && eligible[cand]) begin
        winnerFound = 1'b1;
        winner      = cand;
      end
    end
  end

  always_comb begin
    winX = '0;
    winY = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == REQ_W'(i)) begin
        winX = bus.req_x[10*i +: 10];
        winY = bus.req_y[10*i +: 10];
      end
    end
  end

  // Slot choice looks only at the registered busy mask, so a slot freed this edge waits one frame.
  always_comb begin
    slotFound = 1'b0;
    freeSlot  = '0;
    for (int k = NUM_SLOTS-1; k >= 0; k--) begin
      if (!slot_busy_q[k]) begin
        slotFound = 1'b1;
        freeSlot  = SLOT_W'(k);
      end
    end
  end

  assign grant = grantEn && winnerFound && slotFound;

  always_comb begin
    slot_busy_d = slot_busy_q & ~bus.slot_free;
    cool_d      = '0;
    ptr_d       = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cool_d[i] = (cool_q[i] != 8'd0) ? cool_q[i] - 8'd1 : 8'd0;
    end
    if (grant) begin
      slot_busy_d[freeSlot] = 1'b1;
      cool_d[winner]        = 8'(COOLDOWN);
      ptr_d                 = (winner == REQ_W'(NUM_REQ-1)) ? '0 : winner + REQ_W'(1);
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_busy_q   <= '0;
      cool_q        <= '0;
      ptr_q         <= '0;
      spawn_valid_q <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_src_q   <= '0;
      spawn_x_q     <= '0;
      spawn_y_q     <= '0;
    end else if (startScreen) begin
      slot_busy_q   <= '0;
      cool_q        <= '0;
      ptr_q         <= '0;
      spawn_valid_q <= 1'b0;
    end else begin
      slot_busy_q   <= slot_busy_d;
      cool_q        <= cool_d;
      ptr_q         <= ptr_d;
      spawn_valid_q <= grant;
      if (grant) begin
        spawn_slot_q <= freeSlot;
        spawn_src_q  <= winner;
        spawn_x_q    <= winX;
        spawn_y_q    <= winY;
      end
    end
  end

  assign bus.spawn_valid = spawn_valid_q;
  assign bus.spawn_slot  = spawn_slot_q;
  assign bus.spawn_src   = spawn_src_q;
  assign bus.spawn_x     = spawn_x_q;
  assign bus.spawn_y     = spawn_y_q;
  assign bus.slot_busy   = slot_busy_q;

endmodule
